// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Brings up the clocking-wizard PLL from the board clock domain. Each attempt
//   pulses the PLL reset and then waits a bounded time for lock. A failed attempt
//   is retried a limited number of times before the block parks in FAIL. Once
//   lock is seen, it must stay up for a qualification window before the
//   downstream system reset is released. A lock drop at run time is counted and
//   restarts the whole sequence.
//
// Ports:
//   clk         in   1  board clock, all logic on posedge
//   rst         in   1  asynchronous active-high reset
//   pll_locked  in   1  PLL lock status, asynchronous to clk
//   retry_req   in   1  single-cycle pulse, leaves FAIL for a fresh sequence
//   pll_reset   out  1  active-high reset to the PLL
//   sys_rst     out  1  active-high reset to downstream logic
//   ready       out  1  high only in RUN
//   fail        out  1  high only in FAIL
//   loss_cnt    out  8  run-time lock-loss events, saturating at 255
//   state       out  3  current FSM state (encoding in the table below)
//
// States:
//   state     | code | meaning
//   ----------+------+------------------------------------------------------
//   PLL_RST   |  0   | PLL reset held high for PLL_RST_CYCLES
//   WAIT_LOCK |  1   | PLL released, waiting up to LOCK_TIMEOUT for lock
//   STABLE    |  2   | lock seen, must hold for LOCK_STABLE_CYCLES
//   RUN       |  3   | system reset released, monitoring for lock loss
//   FAIL      |  4   | all attempts used up, waiting for rst or retry_req
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES        = 3,
   parameter int CNT_W              = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       retry_req,
   output logic       pll_reset,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] loss_cnt,
   output logic [2:0] state
);

   // At least one bit so MAX_RETRIES=0 still yields a legal vector.
   localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t             cur_state;
   state_t             nxt_state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [RETRY_W-1:0] retry_cnt;
   logic [RETRY_W-1:0] retry_nxt;
   logic [7:0]         loss_nxt;
   logic               lk_meta;
   logic               lk;

   // ---------------------------------------------------------------------------
   // Lock synchroniser. pll_locked comes from the PLL's own clock domain, so it
   // is only ever observed through lk.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_meta <= 1'b0;
         lk      <= 1'b0;
      end else begin
         lk_meta <= pll_locked;
         lk      <= lk_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // State, cycle counter, retry and loss counters.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_PLL_RST;
         cnt       <= '0;
         retry_cnt <= '0;
         loss_cnt  <= 8'd0;
      end else begin
         cur_state <= nxt_state;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
         loss_cnt  <= loss_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      nxt_state = cur_state;
      retry_nxt = retry_cnt;
      loss_nxt  = loss_cnt;

      unique case (cur_state)
         S_PLL_RST: begin
            if (cnt == RST_LAST) begin
               nxt_state = S_WAIT_LOCK;
            end
         end

         S_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (lk) begin
               nxt_state = S_STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               if (retry_cnt == RETRY_LAST) begin
                  nxt_state = S_FAIL;
               end else begin
                  nxt_state = S_PLL_RST;
                  retry_nxt = retry_cnt + RETRY_W'(1);
               end
            end
         end

         S_STABLE: begin
            // A glitch only restarts the lock wait; it does not burn an attempt.
            if (!lk) begin
               nxt_state = S_WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               nxt_state = S_RUN;
               retry_nxt = '0;
            end
         end

         S_RUN: begin
            if (!lk) begin
               nxt_state = S_PLL_RST;
               if (loss_cnt != 8'hFF) begin
                  loss_nxt = loss_cnt + 8'd1;
               end
            end
         end

         S_FAIL: begin
            if (retry_req) begin
               nxt_state = S_PLL_RST;
               retry_nxt = '0;
            end
         end

         default: begin
            nxt_state = S_PLL_RST;
         end
      endcase

      // Counter restarts on every state entry; in RUN/FAIL it runs freely and
      // its value is never consulted, so wrap-around there is harmless.
      if (nxt_state != cur_state) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Registered Moore outputs, decoded from the next state so they update on the
   // same edge as the state register.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pll_reset <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         pll_reset <= (nxt_state == S_PLL_RST) || (nxt_state == S_FAIL);
         sys_rst   <= (nxt_state != S_RUN);
         ready     <= (nxt_state == S_RUN);
         fail      <= (nxt_state == S_FAIL);
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       retry_req;
   logic       pll_reset;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] loss_cnt;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES     (4),
      .LOCK_TIMEOUT       (20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2),
      .CNT_W              (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .retry_req  (retry_req),
      .pll_reset  (pll_reset),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fail       (fail),
      .loss_cnt   (loss_cnt),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Hold rst across a clock edge and release it just after an edge.
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pll_locked = 1'b0;
      retry_req  = 1'b0;
      rst        = 1'b1;
      #2;
      n_cmp++;
      if ({state, pll_reset, sys_rst, ready, fail, loss_cnt} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_values: got state=%0d pr=%b sr=%b rdy=%b fail=%b loss=%0d, want 0 1 1 0 0 0",
                  state, pll_reset, sys_rst, ready, fail, loss_cnt);
      end
      tick();
      rst = 1'b0;
   endtask

   // Test 1: lock appears 5 cycles after the PLL reset falls.
   // Timeline after pll_locked rises: +1 meta, +2 lk, +3 STABLE (cnt 0),
   // +10 cnt 7, +11 RUN.
   task automatic test_normal_lock();
      ticks(3);
      n_cmp++;
      if (pll_reset !== 1'b1 || state !== 3'd0) begin
         n_err++;
         $display("FAIL rst_pulse_hold: got pr=%b state=%0d, want pr=1 state=0", pll_reset, state);
      end
      tick();
      n_cmp++;
      if (pll_reset !== 1'b0 || state !== 3'd1) begin
         n_err++;
         $display("FAIL rst_pulse_end: got pr=%b state=%0d, want pr=0 state=1", pll_reset, state);
      end
      ticks(5);
      pll_locked = 1'b1;
      ticks(2);
      n_cmp++;
      if (state !== 3'd1) begin
         n_err++;
         $display("FAIL sync_latency: got state=%0d, want 1", state);
      end
      tick();
      n_cmp++;
      if (state !== 3'd2 || sys_rst !== 1'b1) begin
         n_err++;
         $display("FAIL enter_stable: got state=%0d sr=%b, want 2 1", state, sys_rst);
      end
      ticks(7);
      n_cmp++;
      if (state !== 3'd2 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL stable_last: got state=%0d rdy=%b, want 2 0", state, ready);
      end
      tick();
      n_cmp++;
      if (state !== 3'd3 || ready !== 1'b1 || sys_rst !== 1'b0 || pll_reset !== 1'b0) begin
         n_err++;
         $display("FAIL enter_run: got state=%0d rdy=%b sr=%b pr=%b, want 3 1 0 0",
                  state, ready, sys_rst, pll_reset);
      end
      // retry_req must be ignored outside FAIL.
      retry_req = 1'b1;
      tick();
      retry_req = 1'b0;
      tick();
      n_cmp++;
      if (state !== 3'd3) begin
         n_err++;
         $display("FAIL retry_ignored: got state=%0d, want 3", state);
      end
   endtask

   // Test 2: no lock ever. Three attempts of 4 high + 20 low, then FAIL.
   task automatic test_retry_exhaust();
      int n;
      pll_locked = 1'b0;
      do_reset();
      for (int a = 0; a < 3; a++) begin
         n = 0;
         while (pll_reset === 1'b1 && n < 50) begin
            tick();
            n++;
         end
         n_cmp++;
         if (n !== 4) begin
            n_err++;
            $display("FAIL attempt%0d_high: got %0d cycles, want 4", a, n);
         end
         n = 0;
         while (pll_reset === 1'b0 && n < 50) begin
            tick();
            n++;
         end
         n_cmp++;
         if (n !== 20) begin
            n_err++;
            $display("FAIL attempt%0d_wait: got %0d cycles, want 20", a, n);
         end
      end
      n_cmp++;
      if (state !== 3'd4 || fail !== 1'b1 || pll_reset !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL enter_fail: got state=%0d fail=%b pr=%b sr=%b rdy=%b, want 4 1 1 1 0",
                  state, fail, pll_reset, sys_rst, ready);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         n_cmp++;
         if (state !== 3'd4 || fail !== 1'b1) begin
            n_err++;
            $display("FAIL fail_hold[%0d]: got state=%0d fail=%b, want 4 1", i, state, fail);
         end
      end
   endtask

   // Test 3: retry_req from FAIL, then a normal lock.
   task automatic test_retry_req();
      retry_req = 1'b1;
      tick();
      retry_req = 1'b0;
      n_cmp++;
      if (state !== 3'd0 || fail !== 1'b0 || pll_reset !== 1'b1) begin
         n_err++;
         $display("FAIL retry_exit: got state=%0d fail=%b pr=%b, want 0 0 1", state, fail, pll_reset);
      end
      ticks(4);
      n_cmp++;
      if (state !== 3'd1) begin
         n_err++;
         $display("FAIL retry_wait: got state=%0d, want 1", state);
      end
      ticks(5);
      pll_locked = 1'b1;
      ticks(11);
      n_cmp++;
      if (state !== 3'd3 || ready !== 1'b1 || loss_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL retry_run: got state=%0d rdy=%b loss=%0d, want 3 1 0", state, ready, loss_cnt);
      end
   endtask

   // Test 4: one-cycle lock glitch at STABLE cnt=5.
   task automatic test_stable_glitch();
      pll_locked = 1'b1;
      do_reset();
      ticks(4);
      n_cmp++;
      if (state !== 3'd1) begin
         n_err++;
         $display("FAIL glitch_wait: got state=%0d, want 1", state);
      end
      tick();
      n_cmp++;
      if (state !== 3'd2) begin
         n_err++;
         $display("FAIL glitch_stable0: got state=%0d, want 2", state);
      end
      ticks(3);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      n_cmp++;
      if (state !== 3'd2) begin
         n_err++;
         $display("FAIL glitch_cnt5: got state=%0d, want 2", state);
      end
      tick();
      n_cmp++;
      if (state !== 3'd1) begin
         n_err++;
         $display("FAIL glitch_back_wait: got state=%0d, want 1", state);
      end
      tick();
      n_cmp++;
      if (state !== 3'd2) begin
         n_err++;
         $display("FAIL glitch_restable: got state=%0d, want 2", state);
      end
      ticks(7);
      n_cmp++;
      if (state !== 3'd2 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_requalify: got state=%0d rdy=%b, want 2 0", state, ready);
      end
      tick();
      n_cmp++;
      if (state !== 3'd3 || loss_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL glitch_run: got state=%0d loss=%0d, want 3 0", state, loss_cnt);
      end
   endtask

   task automatic lose_and_relock(output bit ok);
      int n;
      ok = 1'b1;
      pll_locked = 1'b0;
      n = 0;
      while (state !== 3'd0 && n < 10) begin
         tick();
         n++;
      end
      if (state !== 3'd0) ok = 1'b0;
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (ready !== 1'b1) ok = 1'b0;
   endtask

   // Test 5: run-time lock loss and loss_cnt saturation.
   task automatic test_lock_loss();
      bit ok;
      int n;
      pll_locked = 1'b0;
      ticks(2);
      n_cmp++;
      if (state !== 3'd3 || sys_rst !== 1'b0) begin
         n_err++;
         $display("FAIL loss_latency: got state=%0d sr=%b, want 3 0", state, sys_rst);
      end
      tick();
      n_cmp++;
      if (state !== 3'd0 || sys_rst !== 1'b1 || pll_reset !== 1'b1 || ready !== 1'b0 || loss_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL loss_exit: got state=%0d sr=%b pr=%b rdy=%b loss=%0d, want 0 1 1 0 1",
                  state, sys_rst, pll_reset, ready, loss_cnt);
      end
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (state !== 3'd3) begin
         n_err++;
         $display("FAIL loss_relock: got state=%0d, want 3", state);
      end
      for (int i = 2; i <= 257; i++) begin
         lose_and_relock(ok);
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL loss_cycle[%0d]: got timeout, want relock to RUN", i);
         end
         if (i == 200 || i == 255) begin
            n_cmp++;
            if (loss_cnt !== 8'(i)) begin
               n_err++;
               $display("FAIL loss_count[%0d]: got %0d, want %0d", i, loss_cnt, i);
            end
         end
      end
      n_cmp++;
      if (loss_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL loss_saturate: got %0d, want 255", loss_cnt);
      end
   endtask

   // Test 6: asynchronous reset in WAIT_LOCK at cnt=10.
   task automatic test_async_reset();
      int n;
      pll_locked = 1'b0;
      n = 0;
      while (state !== 3'd1 && n < 20) begin
         tick();
         n++;
      end
      n_cmp++;
      if (state !== 3'd1) begin
         n_err++;
         $display("FAIL areset_reach_wait: got state=%0d, want 1", state);
      end
      ticks(10);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({state, pll_reset, sys_rst, ready, fail, loss_cnt} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL areset_values: got state=%0d pr=%b sr=%b rdy=%b fail=%b loss=%0d, want 0 1 1 0 0 0",
                  state, pll_reset, sys_rst, ready, fail, loss_cnt);
      end
      tick();
      rst = 1'b0;
      n = 0;
      while (pll_reset === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n !== 4 || state !== 3'd1) begin
         n_err++;
         $display("FAIL areset_restart: got %0d cycles state=%0d, want 4 1", n, state);
      end
   endtask

   initial begin
      test_reset();
      test_normal_lock();
      test_retry_exhaust();
      test_retry_req();
      test_stable_glitch();
      test_lock_loss();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
